// File: rtl/unity_ecc_pkg.sv
// Shared GF(2^8) definitions for the Unity ECC decoder, p(x) = x^8+x^6+x^4+x^3+x^2+x+1.
// Pure constants, types and combinational helpers; no latency.
// No handshake of its own.
package unity_ecc_pkg;

  localparam logic [7:0] GF_POLY_LOW = 8'h5F;

  typedef logic [7:0] gf_sym_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } synd_state_t;

  function automatic gf_sym_t gf_mul_alpha(input gf_sym_t x);
    return {x[6:0], 1'b0} ^ (x[7] ? GF_POLY_LOW : 8'h00);
  endfunction

  // k must be an elaboration-time constant so this unrolls into k xor stages.
  function automatic gf_sym_t gf_mul_alpha_k(input gf_sym_t x, input int k);
    gf_sym_t r;
    r = x;
    for (int i = 0; i < k; i++) begin
      r = gf_mul_alpha(r);
    end
    return r;
  endfunction

endpackage

// File: rtl/gf_horner_cell.sv
// One syndrome accumulator: s <= s*alpha^K ^ sym on each enabled cycle.
// Result visible one cycle after the enabling edge.
// No backpressure; en is the caller's accept strobe, clr wins over en.
module gf_horner_cell
  import unity_ecc_pkg::*;
#(
  parameter int K = 0
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    clr,
  input  logic    en,
  input  gf_sym_t sym,
  output gf_sym_t s
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s <= '0;
    end else if (clr) begin
      s <= '0;
    end else if (en) begin
      s <= gf_mul_alpha_k(s, K) ^ sym;
    end
  end

endmodule

// File: rtl/unity_syndrome_accum.sv
// Streaming syndrome generator: S_k = r(alpha^k), k = 0..NSYND-1, one symbol per cycle.
// syn_valid rises 1 cycle after the codeword's last accepted symbol.
// in_ready drops while a result is pending; syn held until syn_ready, then 1 bubble.
module unity_syndrome_accum
  import unity_ecc_pkg::*;
#(
  parameter int NUM_SYM = 40,
  parameter int NSYND   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         in_sym,
  input  logic               in_last,
  output logic               syn_valid,
  input  logic               syn_ready,
  output logic [8*NSYND-1:0] syn,
  output logic               syn_zero,
  output logic               len_err
);

  localparam int CW = $clog2(NUM_SYM);

  synd_state_t       state_q, state_d;
  logic [CW-1:0]     count_q;
  gf_sym_t           s     [NSYND];
  gf_sym_t           s_nxt [NSYND];
  logic [8*NSYND-1:0] syn_nxt;
  logic              zero_nxt;
  logic              accept;
  logic              at_max;
  logic              cw_end;
  logic              clr;

  assign accept = in_valid && in_ready;
  assign at_max = (count_q == CW'(NUM_SYM - 1));
  assign cw_end = accept && (in_last || at_max);
  assign clr    = (state_q == DONE) && syn_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b1;
    syn_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (cw_end) begin
          state_d = DONE;
        end else if (accept) begin
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (cw_end) begin
          state_d = DONE;
        end
      end
      DONE: begin
        in_ready  = 1'b0;
        syn_valid = 1'b1;
        if (syn_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  for (genvar g = 0; g < NSYND; g++) begin : g_cell
    gf_horner_cell #(.K(g)) u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .en    (accept),
      .sym   (in_sym),
      .s     (s[g])
    );
    // Result register captures the value the cell is about to load, so syn is ready with syn_valid.
    assign s_nxt[g] = gf_mul_alpha_k(s[g], g) ^ in_sym;
    assign syn_nxt[8*g +: 8] = s_nxt[g];
  end

  always_comb begin
    zero_nxt = 1'b1;
    for (int k = 0; k < NSYND; k++) begin
      if (s_nxt[k] != 8'h00) begin
        zero_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      syn      <= '0;
      syn_zero <= 1'b0;
      len_err  <= 1'b0;
    end else begin
      if (clr) begin
        count_q <= '0;
      end else if (accept) begin
        count_q <= count_q + 1'b1;
      end
      if (cw_end) begin
        syn      <= syn_nxt;
        syn_zero <= zero_nxt;
        len_err  <= !(in_last && at_max);
      end
    end
  end

endmodule
